// File: rtl/mem_responder.sv
// mem_responder: word-addressed synchronous memory on the CPU memory-side
// strobes. Accepts one request at a time, inserts WAIT_CYCLES wait states,
// performs the access, pulses done (and err for illegal requests), then
// re-arms only once both strobes have dropped.
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic        NO_WAIT   = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [3:0]          wait_cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                read_r;
    logic                write_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic                accept_s;
    logic                legal_s;
    logic                mem_we_s;
    logic [IDX_W-1:0]    mem_idx_s;

    logic [DATA_W-1:0]   mem [DEPTH];

    // A request is legal when exactly one strobe is set and the word exists.
    function automatic logic req_is_legal(input logic rd,
                                          input logic wr,
                                          input logic [ADDR_W-1:0] a);
        logic [31:0] a_ext;
        a_ext = 32'(a);
        return !(rd && wr) && (a_ext < DEPTH_U);
    endfunction

    assign accept_s  = (state_r == ST_IDLE) && (read || write);
    assign legal_s   = req_is_legal(read_r, write_r, addr_r);
    assign mem_idx_s = addr_r[IDX_W-1:0];

    // State register; asynchronous reset aborts any request in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and array write enable.
    always_comb begin
        state_next_s = state_r;
        mem_we_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (read || write) begin
                    if (NO_WAIT) begin
                        state_next_s = ST_ACCESS;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                state_next_s = ST_HOLD;
                if (write_r && legal_s) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            ST_HOLD: begin
                // Level-held strobes park here so they never retrigger.
                if (!read && !write) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Capture the request on acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            read_r  <= 1'b0;
            write_r <= 1'b0;
        end else if (accept_s) begin
            addr_r  <= addr;
            wdata_r <= wdata;
            read_r  <= read;
            write_r <= write;
        end
    end

    // Wait-state counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= 4'd0;
        end else if (accept_s) begin
            wait_cnt_r <= WAIT_LOAD;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // Registered handshake outputs and read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r <= {DATA_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r <= accept_s;
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                end
                ST_WAIT: begin
                    busy_r <= 1'b1;
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                end
                ST_ACCESS: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    if (!legal_s) begin
                        err_r   <= 1'b1;
                        rdata_r <= {DATA_W{1'b0}};
                    end else begin
                        err_r <= 1'b0;
                        if (read_r) begin
                            rdata_r <= mem[mem_idx_s];
                        end
                    end
                end
                ST_HOLD: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; contents are not reset and change only on a legal write.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_idx_s] <= wdata_r;
        end
    end

    assign rdata = rdata_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances cover WAIT_CYCLES 1/0/3
// and a 256-word array; each request is timed from its acceptance edge.
module tb_mem_responder;

    localparam int ND = 4;

    logic        clk;
    logic        reset_n [ND];
    logic [8:0]  addr    [ND];
    logic [31:0] wdata   [ND];
    logic        rd      [ND];
    logic        wr      [ND];
    logic [31:0] rdata   [ND];
    logic        busy    [ND];
    logic        done    [ND];
    logic        err     [ND];

    int n_total;
    int n_bad;
    int lat_exp [ND];

    mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset_n(reset_n[0]), .addr(addr[0]), .wdata(wdata[0]),
        .read(rd[0]), .write(wr[0]), .rdata(rdata[0]), .busy(busy[0]),
        .done(done[0]), .err(err[0]));

    mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset_n(reset_n[1]), .addr(addr[1]), .wdata(wdata[1]),
        .read(rd[1]), .write(wr[1]), .rdata(rdata[1]), .busy(busy[1]),
        .done(done[1]), .err(err[1]));

    mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset_n(reset_n[2]), .addr(addr[2]), .wdata(wdata[2]),
        .read(rd[2]), .write(wr[2]), .rdata(rdata[2]), .busy(busy[2]),
        .done(done[2]), .err(err[2]));

    mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_CYCLES(1)) u_d256 (
        .clk(clk), .reset_n(reset_n[3]), .addr(addr[3]), .wdata(wdata[3]),
        .read(rd[3]), .write(wr[3]), .rdata(rdata[3]), .busy(busy[3]),
        .done(done[3]), .err(err[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One request: a2/~wd are driven after acceptance to prove latching.
    task automatic do_req(input int d, input logic r, input logic w,
                          input logic [8:0] a, input logic [8:0] a2,
                          input logic [31:0] wd, input logic exp_err,
                          input logic chk_rd, input logic [31:0] exp_rd);
        int   cnt;
        logic seen;
        @(negedge clk);
        addr[d] = a; wdata[d] = wd; rd[d] = r; wr[d] = w;
        cnt = 0; seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) begin
                check_eq("busy_after_e0", 32'(busy[d]), 32'd1);
                addr[d]  = a2;
                wdata[d] = ~wd;
            end
            seen = done[d];
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(cnt - 1), 32'(lat_exp[d]));
        check_eq("err_at_done", 32'(err[d]), 32'(exp_err));
        check_eq("busy_at_done", 32'(busy[d]), 32'd0);
        if (chk_rd) check_eq("rdata", rdata[d], exp_rd);
        @(negedge clk);
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(posedge clk); #1;
        check_eq("done_clear", 32'(done[d]), 32'd0);
        check_eq("err_clear", 32'(err[d]), 32'd0);
        @(posedge clk);
    endtask

    // Count done pulses over n cycles.
    task automatic count_done(input int d, input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done[d]) pulses++;
        end
    endtask

    initial begin
        int pulses;
        n_total = 0; n_bad = 0;
        lat_exp[0] = 2; lat_exp[1] = 1; lat_exp[2] = 4; lat_exp[3] = 2;
        for (int i = 0; i < ND; i++) begin
            reset_n[i] = 1'b0; addr[i] = 9'd0; wdata[i] = 32'd0;
            rd[i] = 1'b0; wr[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            check_eq("rst_busy", 32'(busy[i]), 32'd0);
            check_eq("rst_done", 32'(done[i]), 32'd0);
            check_eq("rst_err", 32'(err[i]), 32'd0);
            check_eq("rst_rdata", rdata[i], 32'd0);
        end
        @(negedge clk);
        for (int i = 0; i < ND; i++) reset_n[i] = 1'b1;
        @(posedge clk);

        // Write then read, WAIT_CYCLES=1.
        do_req(0, 1'b0, 1'b1, 9'h005, 9'h005, 32'h12345678, 1'b0, 1'b0, 32'd0);
        do_req(0, 1'b1, 1'b0, 9'h005, 9'h005, 32'h0, 1'b0, 1'b1, 32'h12345678);

        // Level-held read yields one pulse until dropped and re-raised.
        @(negedge clk); addr[0] = 9'h005; rd[0] = 1'b1;
        count_done(0, 10, pulses);
        check_eq("held_pulses", 32'(pulses), 32'd1);
        check_eq("held_rdata", rdata[0], 32'h12345678);
        @(negedge clk); rd[0] = 1'b0;
        @(posedge clk);
        @(negedge clk); rd[0] = 1'b1;
        count_done(0, 6, pulses);
        check_eq("rearm_pulses", 32'(pulses), 32'd1);
        @(negedge clk); rd[0] = 1'b0;
        repeat (2) @(posedge clk);

        // Illegal: both strobes; array untouched, rdata cleared.
        do_req(0, 1'b0, 1'b1, 9'h010, 9'h010, 32'hAAAA5555, 1'b0, 1'b0, 32'd0);
        do_req(0, 1'b1, 1'b0, 9'h010, 9'h010, 32'h0, 1'b0, 1'b1, 32'hAAAA5555);
        do_req(0, 1'b1, 1'b1, 9'h010, 9'h010, 32'h0F0F0F0F, 1'b1, 1'b1, 32'h0);
        do_req(0, 1'b1, 1'b0, 9'h010, 9'h010, 32'h0, 1'b0, 1'b1, 32'hAAAA5555);

        // WAIT_CYCLES=0 and 3 at the top address.
        do_req(1, 1'b0, 1'b1, 9'h1FF, 9'h1FF, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
        do_req(1, 1'b1, 1'b0, 9'h1FF, 9'h1FF, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        do_req(2, 1'b0, 1'b1, 9'h1FF, 9'h1FF, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
        do_req(2, 1'b1, 1'b0, 9'h1FF, 9'h1FF, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

        // Address changed during WAIT: access uses the latched 0x030.
        do_req(2, 1'b0, 1'b1, 9'h030, 9'h030, 32'h11111111, 1'b0, 1'b0, 32'd0);
        do_req(2, 1'b0, 1'b1, 9'h031, 9'h031, 32'h22222222, 1'b0, 1'b0, 32'd0);
        do_req(2, 1'b1, 1'b0, 9'h030, 9'h031, 32'h0, 1'b0, 1'b1, 32'h11111111);
        do_req(2, 1'b1, 1'b0, 9'h031, 9'h031, 32'h0, 1'b0, 1'b1, 32'h22222222);

        // DEPTH=256: last word legal, 0x100 illegal.
        do_req(3, 1'b0, 1'b1, 9'h0FF, 9'h0FF, 32'h0BADF00D, 1'b0, 1'b0, 32'd0);
        do_req(3, 1'b1, 1'b0, 9'h0FF, 9'h0FF, 32'h0, 1'b0, 1'b1, 32'h0BADF00D);
        do_req(3, 1'b1, 1'b0, 9'h100, 9'h100, 32'h0, 1'b1, 1'b1, 32'h0);

        // Reset during WAIT aborts a pending write.
        do_req(2, 1'b0, 1'b1, 9'h020, 9'h020, 32'h00000001, 1'b0, 1'b0, 32'd0);
        do_req(2, 1'b1, 1'b0, 9'h020, 9'h020, 32'h0, 1'b0, 1'b1, 32'h00000001);
        @(negedge clk); addr[2] = 9'h020; wdata[2] = 32'hFFFFFFFF; wr[2] = 1'b1;
        @(posedge clk); #1;
        check_eq("busy_pre_rst", 32'(busy[2]), 32'd1);
        #2 reset_n[2] = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy[2]), 32'd0);
        check_eq("mid_rst_done", 32'(done[2]), 32'd0);
        check_eq("mid_rst_rdata", rdata[2], 32'd0);
        @(negedge clk); wr[2] = 1'b0; reset_n[2] = 1'b1;
        repeat (6) @(posedge clk);
        do_req(2, 1'b1, 1'b0, 9'h020, 9'h020, 32'h0, 1'b0, 1'b1, 32'h00000001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed synchronous memory that answers the CPU's memory-side signals (MAR address, MDR write data, `read`/`write` strobes). It is the memory end of the datapath/control-unit interface. It accepts one request at a time, inserts a programmable number of wait states, performs the access, returns read data with a one-cycle `done` pulse, then re-arms only after the strobes drop. It also flags illegal requests (both strobes high, out-of-range address) without touching the array.

## Interface
- `DATA_W`, default 32, data word width.
- `ADDR_W`, default 9, address width.
- `DEPTH`, default 512, number of implemented words; addresses ≥ DEPTH are illegal.
- `WAIT_CYCLES`, default 1, wait states inserted before each access (0–15).
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `addr`  in  ADDR_W  word address (driven from MAR).
- `wdata`  in  DATA_W  write data (driven from MDR).
- `read`  in  1  read request, level.
- `write`  in  1  write request, level.
- `rdata`  out  DATA_W  registered read data.
- `busy`  out  1  request accepted, access not yet complete.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse for an illegal request; coincides with `done`.

## Operation
- States: IDLE, WAIT, ACCESS, HOLD.
- Reset values: state=IDLE, `rdata`=0, `busy`=0, `done`=0, `err`=0, wait counter=0. Array contents are not reset. They are undefined until written.
- IDLE: on an edge with `read|write`=1:
  - latch `addr`, `wdata`, `read`, `write` into request registers;
  - set `busy`=1;
  - go to WAIT with counter=WAIT_CYCLES-1, or directly to ACCESS if WAIT_CYCLES=0.
- WAIT: counter decrements each edge. At count 0 the next edge moves to ACCESS. Input changes during WAIT are ignored; latched values are used.
- ACCESS, one edge, then go to HOLD:
  - Legal read: `rdata` <= mem[addr_q].
  - Legal write: mem[addr_q] <= wdata_q; `rdata` unchanged.
  - Illegal request (read_q & write_q, or addr_q ≥ DEPTH): no array access, `rdata` <= 0, `err`=1.
  - On the same edge: `done`=1, `busy`=0.
- HOLD:
  - `done` and `err` clear on the first edge.
  - Return to IDLE on the first edge where `read`=0 and `write`=0; otherwise remain in HOLD.
  - A level-held strobe therefore never triggers a second access.
- `rdata` holds its value until the next completed read or illegal request.
- Reset asserted mid-operation: return immediately to IDLE with reset outputs. A pending write is aborted and the array is unchanged.

## Timing
- E0 = the acceptance edge in IDLE.
- `done` rises after edge E0+WAIT_CYCLES+1 and is high for exactly one cycle.
- Read latency is WAIT_CYCLES+2 edges from request to the `done` high-to-low edge. Data is valid while `done`=1 and stays valid afterwards.
- `busy` is high from after E0 until after the ACCESS edge.
- A written word is readable by any request accepted after its `done`.
- Minimum request spacing: WAIT_CYCLES+3 edges. This is reached when strobes drop during the `done` cycle.
- No combinational path from inputs to outputs.

## Test plan
- Write then read, WAIT_CYCLES=1:
  - `write` addr=0x005, wdata=0x12345678 → `done` one cycle, 2 edges after E0.
  - Strobe dropped, then `read` addr=0x005 → `rdata`=0x12345678 with `done`; `err`=0.
- Level-held `read`, held 10 cycles at addr=0x005 → exactly one `done` pulse. A new `done` appears only after `read` is dropped and re-raised.
- WAIT_CYCLES=0 and WAIT_CYCLES=3, read addr=0x1FF after writing 0xDEADBEEF → `done` after E0+1 and E0+4 respectively; data correct.
- Illegal requests:
  - `read` and `write` together at addr=0x010 holding 0xAAAA5555 → `err`=1 and `done`=1 together, `rdata`=0, mem[0x010] still 0xAAAA5555.
  - With DEPTH=256, read addr=0x100 → `err` pulse.
- Reset mid-write: `write` addr=0x020, wdata=0xFFFFFFFF, `reset_n` low during WAIT → outputs at reset values immediately. A later read of 0x020 returns the prior value, 0x00000001.
- Inputs changed during WAIT (addr 0x030→0x031 after E0) → the access uses 0x030.
